// File: rtl/count_pkg.sv
// count_pkg: shared types and 7-segment encoding for the count_unit block.
//   bcd_t      4-bit BCD digit, always 0..9 in legal state.
//   SEG_*      active-low segment codes, bit0=a .. bit6=g, bit7=dp (kept off).
//   seg_enc()  digit -> segment code; anything outside 0..9 blanks the digit.
package count_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_enc(input bcd_t d);
        case (d)
            4'd0:    seg_enc = SEG_0;
            4'd1:    seg_enc = SEG_1;
            4'd2:    seg_enc = SEG_2;
            4'd3:    seg_enc = SEG_3;
            4'd4:    seg_enc = SEG_4;
            4'd5:    seg_enc = SEG_5;
            4'd6:    seg_enc = SEG_6;
            4'd7:    seg_enc = SEG_7;
            4'd8:    seg_enc = SEG_8;
            4'd9:    seg_enc = SEG_9;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/count_unit_seg7_dec.sv
// seg7_dec: combinational BCD -> 7-segment decoder, one per display digit.
//   bcd  in   4  digit value
//   seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
module seg7_dec
    import count_pkg::*;
(
    input  bcd_t       bcd,
    output logic [7:0] seg
);

    assign seg = seg_enc(bcd);

endmodule

// File: rtl/count_unit.sv
// count_unit: 4-digit BCD up/down counter stepped by a clock prescaler,
// driving four 7-segment displays directly.
//   clk        system clock, all state on rising edge
//   KEY[0]     synchronous active-low reset (KEY[3:1] unused)
//   sw[0]      run, sw[1] down, sw[2] clear (sw[17:3] unused)
//   hex1..hex4 7-seg outputs, thousands..ones, combinational from the digits
module count_unit
    import count_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic [3:0]  KEY,
    input  logic [17:0] sw,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam int               NUM_DIG  = 4;

    // Register names are probed hierarchically; keep them.
    bcd_t             num1, num2, num3, num4;
    logic [CNT_W-1:0] cnt;

    // digits[0] is the ones digit so the carry chain walks upward by index.
    logic [NUM_DIG-1:0][3:0] digits;
    logic [NUM_DIG-1:0][3:0] nxt;
    logic [NUM_DIG-1:0][7:0] segs;
    logic                    carry;

    assign digits = {num1, num2, num3, num4};

    // Ripple carry/borrow: a digit moves only while every lower digit wrapped.
    always_comb begin
        nxt   = digits;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (carry) begin
                if (sw[1]) begin
                    if (digits[i] == 4'd0) begin
                        nxt[i] = 4'd9;
                    end else begin
                        nxt[i] = digits[i] - 4'd1;
                        carry  = 1'b0;
                    end
                end else begin
                    if (digits[i] == 4'd9) begin
                        nxt[i] = 4'd0;
                    end else begin
                        nxt[i] = digits[i] + 4'd1;
                        carry  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!KEY[0] || sw[2]) begin
            // Reset and clear both drop any partial prescaler period.
            cnt  <= '0;
            num1 <= '0;
            num2 <= '0;
            num3 <= '0;
            num4 <= '0;
        end else if (sw[0]) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                num1 <= nxt[3];
                num2 <= nxt[2];
                num3 <= nxt[1];
                num4 <= nxt[0];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
        seg7_dec u_dec (
            .bcd (digits[g]),
            .seg (segs[g])
        );
    end

    assign hex4 = segs[0];
    assign hex3 = segs[1];
    assign hex2 = segs[2];
    assign hex1 = segs[3];

    logic unused_inputs;
    assign unused_inputs = ^{KEY[3:1], sw[17:3]};

endmodule

// File: tb/tb_count_unit.sv
// Testbench for count_unit with TICK_DIV=4. Stimulus pushes expected
// {cycle, digits, prescaler} snapshots; a negedge monitor compares them.
module tb_count_unit;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    logic        clk;
    logic [3:0]  KEY;
    logic [17:0] sw;
    logic [7:0]  hex1, hex2, hex3, hex4;

    count_unit #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .KEY  (KEY),
        .sw   (sw),
        .hex1 (hex1),
        .hex2 (hex2),
        .hex3 (hex3),
        .hex4 (hex4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [15:0]      num;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] seg_ref(input logic [3:0] d);
        logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return (d < 4'd10) ? t[d] : 8'hFF;
    endfunction

    // Monitor: state after edge N is checked at the falling edge that follows it.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_check cyc=%0d now=%0d", e.cyc, cyc);
            end else begin
                n_cmp++;
                if ({dut.num1, dut.num2, dut.num3, dut.num4} !== e.num) begin
                    n_bad++;
                    $display("FAIL num cyc=%0d got=%h exp=%h", cyc,
                             {dut.num1, dut.num2, dut.num3, dut.num4}, e.num);
                end
                n_cmp++;
                if (dut.cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL cnt cyc=%0d got=%0d exp=%0d", cyc, dut.cnt, e.cnt);
                end
                n_cmp++;
                if ({hex1, hex2, hex3, hex4} !== {seg_ref(e.num[15:12]), seg_ref(e.num[11:8]),
                                                  seg_ref(e.num[7:4]), seg_ref(e.num[3:0])}) begin
                    n_bad++;
                    $display("FAIL hex cyc=%0d got=%h exp_num=%h", cyc,
                             {hex1, hex2, hex3, hex4}, e.num);
                end
            end
        end
    end

    task automatic expect_at(input int dly, input logic [15:0] num, input int c);
        exp_t x;
        x.cyc = cyc + dly;
        x.num = num;
        x.cnt = CNT_W'(c);
        q.push_back(x);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. reset
        KEY = 4'h0;
        sw  = 18'h0;
        wait_edges(2);
        expect_at(0, 16'h0000, 0);

        // 2. run 40 cycles -> 10 steps
        KEY = 4'h1;
        sw  = 18'h1;
        expect_at(3,  16'h0000, 3);
        expect_at(4,  16'h0001, 0);
        expect_at(40, 16'h0010, 0);
        wait_edges(40);

        // 3. hold mid-period, then resume for the remaining period
        expect_at(2, 16'h0010, 2);
        wait_edges(2);
        sw = 18'h0;
        expect_at(20, 16'h0010, 2);
        wait_edges(20);
        sw = 18'h1;
        expect_at(1, 16'h0010, 3);
        expect_at(2, 16'h0011, 0);
        wait_edges(2);

        // 4. step up to 9999 through the carry boundaries, wrap, then down-wrap
        expect_at(352,   16'h0099, 0);
        expect_at(356,   16'h0100, 0);
        expect_at(3952,  16'h0999, 0);
        expect_at(3956,  16'h1000, 0);
        expect_at(39952, 16'h9999, 0);
        wait_edges(39952);
        expect_at(4, 16'h0000, 0);
        wait_edges(4);
        sw = 18'h3;
        expect_at(4, 16'h9999, 0);
        expect_at(8, 16'h9998, 0);
        wait_edges(8);

        // 5. clear while counting at 0123
        sw  = 18'h1;
        KEY = 4'h0;
        wait_edges(1);
        KEY = 4'h1;
        expect_at(0,   16'h0000, 0);
        expect_at(492, 16'h0123, 0);
        expect_at(494, 16'h0123, 2);
        wait_edges(494);
        sw = 18'h5;
        expect_at(1, 16'h0000, 0);
        expect_at(5, 16'h0000, 0);
        wait_edges(5);
        sw = 18'h1;
        expect_at(3, 16'h0000, 3);
        expect_at(4, 16'h0001, 0);
        wait_edges(4);

        // direction change mid-period keeps the prescaler running
        expect_at(2, 16'h0001, 2);
        wait_edges(2);
        sw = 18'h3;
        expect_at(1, 16'h0001, 3);
        expect_at(2, 16'h0000, 0);
        wait_edges(2);
        sw = 18'h1;

        // 6. reset at 0456 while running, then first step 4 cycles after release
        expect_at(1824, 16'h0456, 0);
        expect_at(1825, 16'h0456, 1);
        wait_edges(1825);
        KEY = 4'h0;
        expect_at(1, 16'h0000, 0);
        wait_edges(1);
        KEY = 4'h1;
        expect_at(3, 16'h0000, 3);
        expect_at(4, 16'h0001, 0);
        wait_edges(4);

        wait_edges(2);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL unchecked cyc=%0d exp=%h", e.cyc, e.num);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
